jt900h_muldiv: RTL
==================

Name: jt900h_muldiv

Overview:
- Parametrised, iterative multiply/divide unit for the TLCS-900H core. It is the multi-cycle companion to the single-cycle ALU.
- Executes MUL, MULS, DIV and DIVS at operand width W, one radix-2 step per enabled cycle.
- Results are returned through a start/busy/done handshake to the instruction sequencer.
- Provides the overflow flag, and divide-by-zero handling, that the combinational ALU lacks.

Parameters:
- W, 16: operand width. Product and dividend are 2W bits. Legal values are even, 4..32; 8 and 16 are used by the core.
- SIGNED_EN, 1: when 0, MULS/DIVS behave as MUL/DIV, and sign-fix logic is removed.

Ports:
- rst  in  1  asynchronous, active-low reset.
- clk  in  1  clock.
- cen  in  1  clock enable. All state advances only on clk edges with cen=1.
- start  in  1  request. Sampled only when cen=1 and in IDLE.
- op  in  2  operation: 00 MUL, 01 MULS, 10 DIV, 11 DIVS.
- a  in  2W  for MUL/MULS, a[W-1:0] is the multiplicand and upper bits are ignored; for DIV/DIVS, the full dividend.
- b  in  W  multiplier or divisor.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-enabled-cycle pulse; rslt and v are valid.
- rslt  out  2W  MUL: product. DIV: {remainder[W-1:0], quotient[W-1:0]}.
- v  out  1  division overflow / divide-by-zero. Always 0 for MUL.

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, done=0, rslt=0, v=0; internal registers cleared. Reset mid-operation aborts, with no done.
- cen=0: everything frozen, including done; a pulse lasts exactly one cen=1 cycle. All counts below are in cen=1 cycles.
- Operands a, b and op are latched at accept; later input changes are ignored.
- start while busy or done is ignored. No queueing.
- IDLE -> PREP on start.
  - Signed ops: take magnitudes and record sa=sign(operand a), sb=sign(b).
  - MUL/MULS sign source: a[W-1].
  - DIV/DIVS sign source: a[2W-1].
- PREP checks (division only):
  - b==0: v=1, go to FIX, skipping ITER.
  - Unsigned DIV with a[2W-1:W] >= b: v=1, go to FIX.
  - Otherwise go to ITER with counter=W-1.
- ITER: one step per cycle.
  - Multiply: shift-add.
  - Divide: restoring shift-subtract, one quotient bit per step.
  - Counter decrements; at counter 0, go to FIX.
- FIX: apply signs.
  - Product negated when sa^sb.
  - Quotient negated when sa^sb.
  - Remainder takes the sign of the dividend (sa).
  - Signed overflow when the quotient falls outside [-2^(W-1), 2^(W-1)-1]; this sets v=1.
  - Then go to DONE.
- Result when v=1: rslt = latched a, unchanged, for all overflow and div-by-zero cases.
- DONE: done=1 for one cycle, busy=0, then IDLE. rslt and v hold until the next accepted start; they are cleared only by reset.
- Latency, normal case: done is asserted W+2 cycles after the accepting edge: PREP 1, ITER W, FIX 1.
- Latency, early-exit case (zero divisor / unsigned overflow): done is asserted 2 cycles after the accepting edge.
- Signed overflow is detected in FIX, so it always takes full latency.
- start coinciding with the DONE cycle is ignored. A new start is accepted from the next cycle in IDLE.
- Product width rule: the full 2W product never overflows; v=0.

Decomposition:
- Include file jt900h_muldiv.vh holds the localparams for op codes (OP_MUL, OP_MULS, OP_DIV, OP_DIVS) and FSM states (IDLE, PREP, ITER, FIX, DONE). The sequencer shares it for op encoding.
- One natural combinational sub-module: jt900h_muldiv_step (parameter W). It takes the partial accumulator, operand and mode, and returns the next accumulator plus the quotient bit or add-carry.

Test Plan:
- MUL, W=16, a=0x00001234, b=0x5678 -> done at cycle 18 after accept; rslt=0x06260060, v=0.
- MULS, a=0x0000FFFF, b=0x0002 -> rslt=0xFFFFFFFE, v=0. Also check MULS 0x8000*0x8000 -> 0x40000000.
- DIV, a=0x00010000, b=0x0010 -> rslt=0x00001000 (rem 0, quot 0x1000), v=0. DIVS a=0xFFFFFFF9, b=0x0002 -> rslt=0xFFFFFFFD (rem -1, quot -3), v=0.
- DIV a=0x12345678, b=0 -> done 2 cycles after accept, v=1, rslt=0x12345678. DIV a=0x00100000, b=0x0010 -> same early exit, v=1.
- DIVS a=0x80000000, b=0x0001 -> full latency (18 cycles), v=1, rslt=0x80000000.
- Run MUL with cen toggling 1-of-3 -> identical result after 18 enabled cycles. Pulse start while busy -> ignored. Drop rst mid-ITER -> busy=0, done never pulses, rslt=0.

Source files
------------

// File: rtl/jt900h_muldiv_pkg.sv
// Shared definitions for the TLCS-900H multiply/divide unit: operation
// encodings (also used by the instruction sequencer), FSM state type and
// small op-decode helpers.
package jt900h_muldiv_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULS = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_DIVS = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Division ops share bit 1 of the encoding
  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVS);
  endfunction

  // Signed ops share bit 0 of the encoding
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULS) || (op == OP_DIVS);
  endfunction

endpackage

// File: rtl/jt900h_muldiv_if.sv
// Sequencer <-> multiply/divide unit handshake.
//   start/op/a/b : request and operands (master -> slave)
//   busy/done    : progress and one-cycle completion pulse (slave -> master)
//   rslt/v       : result and overflow / divide-by-zero flag (slave -> master)
interface jt900h_muldiv_if #(
  parameter int unsigned W = 16
) ();

  logic           start;
  logic [1:0]     op;
  logic [2*W-1:0] a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] rslt;
  logic           v;

  modport master (output start, op, a, b, input busy, done, rslt, v);
  modport slave  (input start, op, a, b, output busy, done, rslt, v);

endinterface

// File: rtl/jt900h_muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes.
//   acc  : partial accumulator {hi, lo}
//   opnd : multiplicand (multiply) or divisor (divide)
//   div  : 1 = restoring shift-subtract, 0 = shift-add
//   nxt  : next accumulator with the slot for qbit left at zero
//          (bit 0 for divide, bit 2W-1 for multiply)
//   qbit : quotient bit (divide) or add carry (multiply)
module jt900h_muldiv_step #(
  parameter int unsigned W = 16
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   opnd,
  input  logic           div,
  output logic [2*W-1:0] nxt,
  output logic           qbit
);

  logic [W:0]   sum;
  logic [W:0]   top;
  logic [W-1:0] diff;

  always_comb begin
    sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : W'(0))};
    // Partial remainder after the left shift needs W+1 bits
    top  = acc[2*W-1:W-1];
    // Only taken when top >= opnd, so the low W bits are exact
    diff = top[W-1:0] - opnd;
    nxt  = '0;
    qbit = 1'b0;
    if (div) begin
      qbit = (top >= {1'b0, opnd});
      nxt  = {(qbit ? diff : top[W-1:0]), acc[W-2:0], 1'b0};
    end else begin
      qbit = sum[W];
      nxt  = {1'b0, sum[W-1:0], acc[W-1:1]};
    end
  end

endmodule

// File: rtl/jt900h_muldiv.sv
// Iterative multiply/divide unit (MUL, MULS, DIV, DIVS) for the TLCS-900H.
//   rst : asynchronous active-low reset
//   clk : clock
//   cen : clock enable, all state advances only when high
//   bus : slave side of the start/busy/done handshake (operands, rslt, v)
// Flow: IDLE -> PREP (magnitudes, early checks) -> ITER (W steps) ->
// FIX (signs, signed overflow) -> DONE (one-cycle done pulse) -> IDLE.
module jt900h_muldiv
  import jt900h_muldiv_pkg::*;
#(
  parameter int unsigned W         = 16,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic           rst,
  input  logic           clk,
  input  logic           cen,
  jt900h_muldiv_if.slave bus
);

  localparam int unsigned W2 = 2 * W;
  localparam int unsigned CW = $clog2(W);
  localparam logic [W-1:0] QMIN = {1'b1, {(W-1){1'b0}}};

  state_t        st;
  logic [1:0]    op_q;
  logic [W2-1:0] a_q;
  logic [W-1:0]  b_q;
  logic [W2-1:0] acc;
  logic [W-1:0]  opnd;
  logic [CW-1:0] cnt;
  logic          sa, sb, ovf, big;
  logic          busy, done, v;
  logic [W2-1:0] rslt;

  logic          is_div, is_sgn;
  logic          sa_c, sb_c, neg_c, sovf_c, fix_ovf_c;
  logic [W-1:0]  am_c, bm_c, quo_c, rem_c;
  logic [W2-1:0] dm_c, prod_c;
  logic [W2-1:0] step_nxt;
  logic          step_bit;

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.rslt = rslt;
  assign bus.v    = v;

  assign is_div = op_is_div(op_q);
  assign is_sgn = SIGNED_EN && op_is_signed(op_q);

  // Operand signs and magnitudes from the latched request
  always_comb begin
    sa_c = is_sgn && (is_div ? a_q[W2-1] : a_q[W-1]);
    sb_c = is_sgn && b_q[W-1];
    am_c = sa_c ? -a_q[W-1:0] : a_q[W-1:0];
    dm_c = sa_c ? -a_q : a_q;
    bm_c = sb_c ? -b_q : b_q;
  end

  // Sign fix-up of the magnitude result and signed quotient range check
  always_comb begin
    neg_c     = sa ^ sb;
    prod_c    = neg_c ? -acc : acc;
    quo_c     = neg_c ? -acc[W-1:0] : acc[W-1:0];
    rem_c     = sa ? -acc[W2-1:W] : acc[W2-1:W];
    // big: magnitude quotient would not even fit in W bits
    sovf_c    = is_div && is_sgn &&
                (big || (neg_c ? (acc[W-1:0] > QMIN) : acc[W-1]));
    fix_ovf_c = ovf || sovf_c;
  end

  jt900h_muldiv_step #(.W(W)) u_step (
    .acc  (acc),
    .opnd (opnd),
    .div  (is_div),
    .nxt  (step_nxt),
    .qbit (step_bit)
  );

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= IDLE;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      opnd <= '0;
      cnt  <= '0;
      sa   <= 1'b0;
      sb   <= 1'b0;
      ovf  <= 1'b0;
      big  <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      rslt <= '0;
      v    <= 1'b0;
    end else if (cen) begin
      case (st)
        IDLE: begin
          if (bus.start) begin
            op_q <= bus.op;
            a_q  <= bus.a;
            b_q  <= bus.b;
            busy <= 1'b1;
            st   <= PREP;
          end
        end
        PREP: begin
          sa  <= sa_c;
          sb  <= sb_c;
          big <= is_div && (dm_c[W2-1:W] >= bm_c);
          if (is_div) begin
            acc  <= dm_c;
            opnd <= bm_c;
          end else begin
            // Multiplier in the low half is consumed LSB-first
            acc  <= {W'(0), bm_c};
            opnd <= am_c;
          end
          if (is_div && ((b_q == '0) || (!is_sgn && (a_q[W2-1:W] >= b_q)))) begin
            ovf <= 1'b1;
            st  <= FIX;
          end else begin
            ovf <= 1'b0;
            cnt <= CW'(W - 1);
            st  <= ITER;
          end
        end
        ITER: begin
          acc <= is_div ? {step_nxt[W2-1:1], step_bit}
                        : {step_bit, step_nxt[W2-2:0]};
          cnt <= cnt - CW'(1);
          if (cnt == '0) st <= FIX;
        end
        FIX: begin
          v    <= fix_ovf_c;
          rslt <= fix_ovf_c ? a_q : (is_div ? {rem_c, quo_c} : prod_c);
          busy <= 1'b0;
          done <= 1'b1;
          st   <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          st   <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
